// File: rtl/counter_updown_mod_pkg.sv
// Shared constants for the up/down counter slice.
//   MODE_WRAP / MODE_SAT : encodings of the sat_mode input
//   DIR_DOWN  / DIR_UP   : encodings of the up_down input
package counter_pkg;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  localparam logic DIR_DOWN  = 1'b0;
  localparam logic DIR_UP    = 1'b1;

endpackage : counter_pkg

// File: rtl/counter_updown_mod_if.sv
// Control/status bundle of the up/down counter.
// Ports (all plain level signals, no handshake; sampled at the rising clock):
//   load, in         : synchronous load of a value (clamped to limit)
//   up_down          : 1 = up, 0 = down
//   count_en, step   : count enable and step size
//   limit            : terminal value, count range 0..limit
//   sat_mode         : 1 = saturate, 0 = wrap modulo limit+1
//   ovf_clr          : clear of the sticky overflow flag
//   count, carry, tc, ovf_sticky : status returned by the counter
// master = controlling logic, slave = the counter.
interface counter_updown_mod_if #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
);

  logic              load;
  logic [WIDTH-1:0]  in;
  logic              up_down;
  logic              count_en;
  logic [STEP_W-1:0] step;
  logic [WIDTH-1:0]  limit;
  logic              sat_mode;
  logic              ovf_clr;
  logic [WIDTH-1:0]  count;
  logic              carry;
  logic              tc;
  logic              ovf_sticky;

  modport master (
    output load, in, up_down, count_en, step, limit, sat_mode, ovf_clr,
    input  count, carry, tc, ovf_sticky
  );

  modport slave (
    input  load, in, up_down, count_en, step, limit, sat_mode, ovf_clr,
    output count, carry, tc, ovf_sticky
  );

endinterface : counter_updown_mod_if

// File: rtl/counter_updown_mod_next_calc.sv
// Combinational next-count calculator.
// Ports:
//   count, step, limit, up_down, sat_mode : current state and controls
//   next_count : count value after one enabled step
//   is_event   : the step wrapped or clipped at a bound
// All arithmetic is done at WIDTH+1 bits so sums and differences are
// compared without truncation. Assumes STEP_W <= WIDTH.
module counter_next_calc
  import counter_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
) (
  input  logic [WIDTH-1:0]  count,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  limit,
  input  logic              up_down,
  input  logic              sat_mode,
  output logic [WIDTH-1:0]  next_count,
  output logic              is_event
);

  logic [WIDTH:0] cnt_x;
  logic [WIDTH:0] lim_x;
  logic [WIDTH:0] step_x;
  logic [WIDTH:0] mod_x;
  logic [WIDTH:0] sum_x;
  logic           sat_eff;

  always_comb begin
    cnt_x  = {1'b0, count};
    lim_x  = {1'b0, limit};
    step_x = (WIDTH+1)'(step);
    mod_x  = lim_x + 1'b1;
    // A step larger than the whole range cannot wrap meaningfully.
    sat_eff = (sat_mode == MODE_SAT) || (step_x > lim_x);

    sum_x      = cnt_x;
    is_event   = 1'b0;
    next_count = count;

    if (step_x == '0) begin
      is_event = 1'b0;
    end else if (cnt_x > lim_x) begin
      // Limit was lowered under the current count.
      is_event   = 1'b1;
      next_count = sat_eff ? limit : '0;
    end else if (up_down == DIR_UP) begin
      sum_x = cnt_x + step_x;
      if (sum_x <= lim_x) begin
        next_count = sum_x[WIDTH-1:0];
      end else begin
        is_event = 1'b1;
        if (sat_eff) begin
          next_count = limit;
        end else begin
          sum_x      = sum_x - mod_x;
          next_count = sum_x[WIDTH-1:0];
        end
      end
    end else begin
      if (step_x <= cnt_x) begin
        sum_x      = cnt_x - step_x;
        next_count = sum_x[WIDTH-1:0];
      end else begin
        is_event = 1'b1;
        if (sat_eff) begin
          next_count = '0;
        end else begin
          sum_x      = cnt_x + mod_x - step_x;
          next_count = sum_x[WIDTH-1:0];
        end
      end
    end
  end

endmodule : counter_next_calc

// File: rtl/counter_updown_mod.sv
// Up/down counter with programmable limit, variable step, wrap or
// saturate mode, registered terminal-count pulse and sticky overflow.
// Ports:
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : counter_updown_mod_if slave modport (controls in, status out)
// Priority at each edge: load > count enable > hold.
// carry is combinational from count, up_down and limit.
module counter_updown_mod
  import counter_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
) (
  input  logic clk,
  input  logic reset_n,
  counter_updown_mod_if.slave bus
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] calc_next;
  logic             calc_event;

  counter_next_calc #(
    .WIDTH  (WIDTH),
    .STEP_W (STEP_W)
  ) u_next_calc (
    .count      (count_q),
    .step       (bus.step),
    .limit      (bus.limit),
    .up_down    (bus.up_down),
    .sat_mode   (bus.sat_mode),
    .next_count (calc_next),
    .is_event   (calc_event)
  );

  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    // A coincident event overrides the clear below.
    ovf_d   = ovf_q & ~bus.ovf_clr;
    if (bus.load) begin
      // Silent clamp: no tc, no overflow.
      count_d = (bus.in > bus.limit) ? bus.limit : bus.in;
    end else if (bus.count_en && (bus.step != '0)) begin
      count_d = calc_next;
      if (calc_event) begin
        tc_d  = 1'b1;
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.count      = count_q;
  assign bus.tc         = tc_q;
  assign bus.ovf_sticky = ovf_q;
  assign bus.carry      = (bus.up_down == DIR_UP) ? (count_q == bus.limit)
                                                  : (count_q == '0);

endmodule : counter_updown_mod

// File: tb/tb_counter_updown_mod.sv
// Directed bench for counter_updown_mod (WIDTH=8, STEP_W=4).
module tb_counter_updown_mod;

  localparam int WIDTH  = 8;
  localparam int STEP_W = 4;

  logic clk;
  logic reset_n;
  int   n_tests;
  int   n_fail;

  counter_updown_mod_if #(.WIDTH(WIDTH), .STEP_W(STEP_W)) bus ();

  counter_updown_mod #(.WIDTH(WIDTH), .STEP_W(STEP_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [WIDTH-1:0] v);
    bus.load     = 1'b1;
    bus.in       = v;
    bus.count_en = 1'b0;
    tick();
    bus.load     = 1'b0;
  endtask

  logic [7:0] exp_cnt4 [5];
  logic       exp_tc4  [5];

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset_n      = 1'b0;
    bus.load     = 1'b0;
    bus.in       = '0;
    bus.up_down  = 1'b0;
    bus.count_en = 1'b0;
    bus.step     = '0;
    bus.limit    = 8'h09;
    bus.sat_mode = 1'b0;
    bus.ovf_clr  = 1'b0;
    repeat (2) tick();
    check("rst_count0", 16'(bus.count), 16'h00);
    reset_n = 1'b1;

    // 1. reset mid-count: down from 0 wraps to 09 (tc=1, ovf=1), then reset
    bus.step     = 4'd1;
    bus.count_en = 1'b1;
    tick();
    check("pre_count", 16'(bus.count), 16'h09);
    check("pre_tc", 16'(bus.tc), 16'h1);
    reset_n = 1'b0;
    #2;
    check("rst_count", 16'(bus.count), 16'h00);
    check("rst_carry_dn", 16'(bus.carry), 16'h1);
    check("rst_tc", 16'(bus.tc), 16'h0);
    check("rst_ovf", 16'(bus.ovf_sticky), 16'h0);
    bus.up_down  = 1'b1;
    bus.limit    = 8'hFF;
    bus.count_en = 1'b0;
    #1;
    check("rst_carry_up", 16'(bus.carry), 16'h0);
    reset_n = 1'b1;

    // 2. load clamp, load beats count_en
    bus.limit    = 8'h09;
    bus.load     = 1'b1;
    bus.count_en = 1'b1;
    bus.in       = 8'h0F;
    tick();
    check("ld_clamp", 16'(bus.count), 16'h09);
    check("ld_clamp_tc", 16'(bus.tc), 16'h0);
    bus.in = 8'h03;
    tick();
    check("ld_03", 16'(bus.count), 16'h03);
    check("ld_03_carry", 16'(bus.carry), 16'h0);
    check("ld_ovf", 16'(bus.ovf_sticky), 16'h0);
    bus.load = 1'b0;

    // 3. mod-10 up wrap from 07
    do_load(8'h07);
    bus.up_down  = 1'b1;
    bus.step     = 4'd1;
    bus.count_en = 1'b1;
    tick();
    check("m10_08", 16'(bus.count), 16'h08);
    check("m10_08_tc", 16'(bus.tc), 16'h0);
    tick();
    check("m10_09", 16'(bus.count), 16'h09);
    check("m10_09_carry", 16'(bus.carry), 16'h1);
    check("m10_09_tc", 16'(bus.tc), 16'h0);
    tick();
    check("m10_00", 16'(bus.count), 16'h00);
    check("m10_00_tc", 16'(bus.tc), 16'h1);
    check("m10_ovf", 16'(bus.ovf_sticky), 16'h1);
    bus.count_en = 1'b0;
    bus.ovf_clr  = 1'b1;
    tick();
    bus.ovf_clr  = 1'b0;
    check("ovf_clr", 16'(bus.ovf_sticky), 16'h0);
    check("hold_tc", 16'(bus.tc), 16'h0);
    check("hold_count", 16'(bus.count), 16'h00);

    // 4. down wrap step 3 from 02
    exp_cnt4 = '{8'h09, 8'h06, 8'h03, 8'h00, 8'h07};
    exp_tc4  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    do_load(8'h02);
    bus.up_down  = 1'b0;
    bus.step     = 4'd3;
    bus.count_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("dn3_cnt%0d", i), 16'(bus.count), 16'(exp_cnt4[i]));
      check($sformatf("dn3_tc%0d", i), 16'(bus.tc), 16'(exp_tc4[i]));
      if (i == 3) check("dn3_carry", 16'(bus.carry), 16'h1);
    end

    // 5. saturate up at FF
    bus.sat_mode = 1'b1;
    bus.limit    = 8'hFF;
    do_load(8'hFC);
    bus.up_down  = 1'b1;
    bus.step     = 4'd4;
    bus.count_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("sat_cnt%0d", i), 16'(bus.count), 16'hFF);
      check($sformatf("sat_tc%0d", i), 16'(bus.tc), 16'h1);
    end
    bus.up_down = 1'b0;
    bus.step    = 4'd0;
    tick();
    check("sat_step0_cnt", 16'(bus.count), 16'hFF);
    check("sat_step0_tc", 16'(bus.tc), 16'h0);
    check("sat_dn_carry", 16'(bus.carry), 16'h0);

    // 6a. ovf_clr coincident with event
    bus.up_down = 1'b1;
    bus.step    = 4'd4;
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
    check("clr_evt_ovf", 16'(bus.ovf_sticky), 16'h1);
    check("clr_evt_tc", 16'(bus.tc), 16'h1);

    // 6b. limit lowered below count, wrap mode -> 00
    bus.sat_mode = 1'b0;
    bus.limit    = 8'h09;
    do_load(8'h08);
    bus.limit    = 8'h05;
    bus.step     = 4'd1;
    bus.count_en = 1'b1;
    tick();
    check("lowlim_wrap", 16'(bus.count), 16'h00);
    check("lowlim_wrap_tc", 16'(bus.tc), 16'h1);

    // 6c. limit lowered below count, saturate mode, counting down -> limit
    bus.sat_mode = 1'b1;
    bus.limit    = 8'h09;
    do_load(8'h08);
    bus.limit    = 8'h05;
    bus.up_down  = 1'b0;
    bus.count_en = 1'b1;
    tick();
    check("lowlim_sat", 16'(bus.count), 16'h05);

    // 6d. step > limit forces saturate in wrap mode: 02+5 > 03 -> 03
    bus.sat_mode = 1'b0;
    bus.limit    = 8'h03;
    do_load(8'h02);
    bus.up_down  = 1'b1;
    bus.step     = 4'd5;
    bus.count_en = 1'b1;
    tick();
    check("big_step_sat", 16'(bus.count), 16'h03);

    // 6e. full-range modulus: FE+3 wraps to 01
    bus.limit = 8'hFF;
    do_load(8'hFE);
    bus.step     = 4'd3;
    bus.count_en = 1'b1;
    tick();
    check("full_wrap", 16'(bus.count), 16'h01);
    check("full_wrap_tc", 16'(bus.tc), 16'h1);
    bus.count_en = 1'b0;
    tick();
    check("full_hold_tc", 16'(bus.tc), 16'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_counter_updown_mod

// File: doc/counter_updown_mod.md
Name: counter_updown_mod

Overview:
Parametrised up/down counter with a programmable modulus, variable step and a wrap-or-saturate mode. It extends the fixed 8-bit up/down counter with a run-time terminal value, a registered terminal-count pulse and a sticky overflow flag. It is a building block for timers, dividers and address generators, driven directly by control logic.

Parameters:
WIDTH, 8, counter and limit width
STEP_W, 4, width of the step input

Ports:
clk  in  1  single system clock, rising edge
reset_n  in  1  asynchronous active-low reset
load  in  1  synchronous load of in
in  in  WIDTH  load value
up_down  in  1  1 = count up, 0 = count down
count_en  in  1  count enable
step  in  STEP_W  increment/decrement amount
limit  in  WIDTH  terminal value; count range 0..limit
sat_mode  in  1  1 = saturate at bounds, 0 = wrap modulo limit+1
ovf_clr  in  1  synchronous clear of ovf_sticky
count  out  WIDTH  current count
carry  out  1  combinational: up_down ? (count==limit) : (count==0)
tc  out  1  registered one-cycle terminal-count pulse
ovf_sticky  out  1  set on any wrap or clip event, held until ovf_clr

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-low on reset_n. The polarity and synchronicity are fixed.
- Reset (asynchronous, no clock needed): count=0, tc=0, ovf_sticky=0. carry then follows from count=0, so carry=1 when up_down=0, and carry=(limit==0) when up_down=1.
- Priority at each rising edge: reset > load > count_en > hold.
- Load: count <= min(in, limit). Clamping is silent: no tc, no ovf.
- Hold: when count_en=0 or step=0, count holds and tc=0.
- Latency: count updates on the edge after the inputs are sampled. carry is combinational from count, up_down and limit.
- Arithmetic: performed at WIDTH+1 bits, no truncation before compare.
- Up, count+step <= limit: count <= count+step.
- Up, count+step > limit (an event):
  - wrap: count <= count+step-(limit+1)
  - saturate: count <= limit
- Down, step <= count: count <= count-step.
- Down, step > count (an event):
  - wrap: count <= count+(limit+1)-step
  - saturate: count <= 0
- step > limit: treated as saturate regardless of sat_mode.
- limit lowered below current count: the next enabled step, up or down, is an event. count <= 0 in wrap mode, limit in saturate mode.
- limit = 2^WIDTH-1: modulus 2^WIDTH. No overflow of the internal WIDTH+1 sum.
- tc: 1 for the cycle following each event edge, otherwise 0. A saturated counter already at its bound with count_en=1 and step>0 produces an event every cycle, so tc stays high.
- ovf_sticky: set on the same edge tc is asserted. ovf_clr clears it, but a coincident event wins and it stays 1.
- Reset mid-count: all state returns to reset values immediately, with no partial update at the next edge.
- No state machine beyond count/tc/ovf registers. No X propagation from unused inputs when load=0 and count_en=0.

Decomposition:
- Package counter_pkg:
  - mode constants MODE_WRAP=0, MODE_SAT=1
  - direction constants DIR_DOWN=0, DIR_UP=1
- Sub-module counter_next_calc: purely combinational. Computes next count and the event flag from count, step, limit, up_down and sat_mode.
- Top level holds the registers, load clamp, priority logic, tc and ovf_sticky.

Test Plan (WIDTH=8, STEP_W=4):
1. Reset: assert reset_n=0 mid-count with up_down=0 -> count=00, carry=1, tc=0, ovf_sticky=0 within 2 time units, no clock edge. Then set up_down=1, limit=FF -> carry=0.
2. Load clamp and priority: limit=09; load=1, count_en=1, in=0F -> count=09, tc=0. Then load in=03 -> count=03, carry=0.
3. Mod-10 up wrap: limit=09, step=1, up, wrap mode, start at 07:
   - count runs 08, 09 (carry=1), 00
   - tc=1 only in the cycle count=00; ovf_sticky=1
   - ovf_clr pulse -> ovf_sticky=0
4. Down wrap with step 3: limit=09, start at 02:
   - count runs 09, 06, 03, 00 (carry=1), 07
   - tc=1 after the 02->09 edge and after the 00->07 edge
5. Saturate: sat_mode=1, limit=FF, step=4, up, start at FC:
   - count becomes FF and holds FF
   - tc stays 1 every enabled cycle
   - switch to down, step=0 -> count holds FF, tc=0
6. Simultaneous and dynamic-limit cases:
   - ovf_clr coincident with an event -> ovf_sticky stays 1
   - with count=08, lower limit to 05 and count up, wrap mode -> count=00, tc=1
